// File: rtl/local_port_sink_if.sv
// ---------------------------------------------------------------------------
// local_port_sink_if
// Flit handshake between a switch local (IP) output port and its sink.
//   data_i      : flit {last, dest addr, data}, driven by the switch
//   wr_ready_in : switch presents a valid flit on data_i
//   r_ready_out : sink can accept a flit this cycle
// Modports: master = switch side, slave = sink side.
// ---------------------------------------------------------------------------
interface local_port_sink_if #(
  parameter int FLIT_SIZE = 13
);
  logic [FLIT_SIZE-1:0] data_i;
  logic                 wr_ready_in;
  logic                 r_ready_out;

  modport master (output data_i, output wr_ready_in, input r_ready_out);
  modport slave  (input data_i, input wr_ready_in, output r_ready_out);
endinterface

// File: rtl/local_port_sink.sv
// ---------------------------------------------------------------------------
// local_port_sink
// Receive endpoint on a switch local output port. Reassembles packets,
// checks that every flit is addressed to ADDR, and keeps saturating
// statistics. Optionally throttles r_ready_out one cycle in STALL_PERIOD.
//
// Ports:
//   clk         : clock, rising edge
//   a_rst       : synchronous active-low reset
//   port        : local_port_sink_if.slave (data_i, wr_ready_in, r_ready_out)
//   pack_done   : one-cycle pulse on good packet completion
//   pack_len    : flit count of the last good packet
//   pack_sum    : XOR checksum of the last good packet
//   pack_cnt    : good packets
//   flit_cnt    : accepted flits (good or dropped)
//   err_cnt     : errored packets
//   busy        : packet in progress (BODY or DROP)
//
// Build option: define RX_CHECKSUM_EN to treat the last flit's data as an
// XOR checksum of the preceding flits; mismatching packets count as errors.
// ---------------------------------------------------------------------------
module local_port_sink #(
  parameter  int DATA_SIZE    = 8,
  parameter  int ADDR_SIZE    = 4,
  parameter  int ADDR         = 0,
  parameter  int MAX_PACK_LEN = 8,
  parameter  int STALL_PERIOD = 0,
  parameter  int CNT_W        = 16,
  localparam int FLIT_SIZE    = DATA_SIZE + ADDR_SIZE + 1,
  localparam int LEN_W        = $clog2(MAX_PACK_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 a_rst,
  local_port_sink_if.slave     port,
  output logic                 pack_done,
  output logic [LEN_W-1:0]     pack_len,
  output logic [DATA_SIZE-1:0] pack_sum,
  output logic [CNT_W-1:0]     pack_cnt,
  output logic [CNT_W-1:0]     flit_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 busy
);

  localparam int STALL_W = (STALL_PERIOD >= 2) ? $clog2(STALL_PERIOD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t               r_state;
  logic                 r_ready;
  logic [STALL_W-1:0]   r_stall_cnt;
  logic [DATA_SIZE-1:0] r_sum;
  logic [LEN_W-1:0]     r_len;

  logic                 w_acc;
  logic                 w_last;
  logic                 w_addr_ok;
  logic [DATA_SIZE-1:0] w_data;
  logic [DATA_SIZE-1:0] w_prev_sum;
  logic [LEN_W-1:0]     w_len_nxt;
  logic                 w_ck_ok;
  logic [DATA_SIZE-1:0] w_rep_sum;

  assign port.r_ready_out = r_ready;
  assign busy             = (r_state != S_IDLE);

  assign w_acc     = port.wr_ready_in & r_ready;
  assign w_last    = port.data_i[FLIT_SIZE-1];
  assign w_addr_ok = (port.data_i[FLIT_SIZE-2:DATA_SIZE] == ADDR_SIZE'(ADDR));
  assign w_data    = port.data_i[DATA_SIZE-1:0];

  // IDLE and BODY share one decision path: in IDLE the flit opens a new
  // packet, so the running sum and length restart from zero.
  assign w_prev_sum = (r_state == S_BODY) ? r_sum : '0;
  assign w_len_nxt  = (r_state == S_BODY) ? r_len + LEN_W'(1) : LEN_W'(1);

`ifdef RX_CHECKSUM_EN
  assign w_ck_ok   = (w_data == w_prev_sum);
  assign w_rep_sum = w_prev_sum;
`else
  assign w_ck_ok   = 1'b1;
  assign w_rep_sum = w_prev_sum ^ w_data;
`endif

  // Ready throttle: ready for the coming cycle is low when the counter
  // sits at its top value, giving 1..1,0 with period STALL_PERIOD.
  always_ff @(posedge clk) begin
    if (!a_rst) begin
      r_ready     <= 1'b0;
      r_stall_cnt <= '0;
    end else if (STALL_PERIOD >= 2) begin
      r_ready     <= (r_stall_cnt != STALL_W'(STALL_PERIOD - 1));
      r_stall_cnt <= (r_stall_cnt == STALL_W'(STALL_PERIOD - 1)) ?
                     '0 : r_stall_cnt + STALL_W'(1);
    end else begin
      r_ready     <= 1'b1;
      r_stall_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      r_state   <= S_IDLE;
      pack_done <= 1'b0;
      pack_len  <= '0;
      pack_sum  <= '0;
      pack_cnt  <= '0;
      flit_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      pack_done <= 1'b0;
      if (w_acc) begin
        flit_cnt <= sat_inc(flit_cnt);
        r_sum    <= w_prev_sum ^ w_data;
        r_len    <= w_len_nxt;
        case (r_state)
          S_IDLE, S_BODY: begin
            if (!w_addr_ok) begin
              err_cnt <= sat_inc(err_cnt);
              r_state <= w_last ? S_IDLE : S_DROP;
            end else if (w_last) begin
              r_state <= S_IDLE;
              if (w_ck_ok) begin
                pack_done <= 1'b1;
                pack_len  <= w_len_nxt;
                pack_sum  <= w_rep_sum;
                pack_cnt  <= sat_inc(pack_cnt);
              end else begin
                err_cnt <= sat_inc(err_cnt);
              end
            end else if (w_len_nxt == LEN_W'(MAX_PACK_LEN)) begin
              // Length limit reached without a last flag: overlength.
              err_cnt <= sat_inc(err_cnt);
              r_state <= S_DROP;
            end else begin
              r_state <= S_BODY;
            end
          end
          S_DROP: begin
            if (w_last) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_local_port_sink.sv
`timescale 1ns/1ps
module tb_local_port_sink;
  localparam int DATA_SIZE    = 8;
  localparam int ADDR_SIZE    = 4;
  localparam int ADDR         = 3;
  localparam int MAX_PACK_LEN = 8;
  localparam int STALL_PERIOD = 4;
  localparam int CNT_W        = 5;
  localparam int FLIT_SIZE    = DATA_SIZE + ADDR_SIZE + 1;
  localparam int LEN_W        = $clog2(MAX_PACK_LEN + 1);
  localparam int CMAX         = (1 << CNT_W) - 1;

  typedef struct {
    logic                 last;
    logic [ADDR_SIZE-1:0] addr;
    logic [DATA_SIZE-1:0] data;
  } flit_t;

  typedef struct {
    int                   len;
    logic [DATA_SIZE-1:0] sum;
  } done_t;

  logic clk = 1'b0;
  logic a_rst = 1'b0;
  always #5 clk = ~clk;

  local_port_sink_if #(.FLIT_SIZE(FLIT_SIZE)) bus ();

  logic                 pack_done;
  logic [LEN_W-1:0]     pack_len;
  logic [DATA_SIZE-1:0] pack_sum;
  logic [CNT_W-1:0]     pack_cnt;
  logic [CNT_W-1:0]     flit_cnt;
  logic [CNT_W-1:0]     err_cnt;
  logic                 busy;

  local_port_sink #(
    .DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .ADDR(ADDR),
    .MAX_PACK_LEN(MAX_PACK_LEN), .STALL_PERIOD(STALL_PERIOD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .a_rst(a_rst), .port(bus),
    .pack_done(pack_done), .pack_len(pack_len), .pack_sum(pack_sum),
    .pack_cnt(pack_cnt), .flit_cnt(flit_cnt), .err_cnt(err_cnt), .busy(busy)
  );

  // Reference state
  int                   checks = 0;
  int                   errors = 0;
  int                   exp_flit = 0, exp_err = 0, exp_pack = 0, exp_len = 0;
  logic [DATA_SIZE-1:0] exp_sum = '0;
  bit                   exp_done = 0, exp_busy = 0;
  done_t                exp_q[$];
  flit_t                pkt[$];
  bit                   mon_en = 0;
  int                   rel_edges = 0;
  int                   cyc = 0, win_lo = 0, win_hi = -1, win_acc = 0;

  // Edges since reset release; the ready pattern is defined from here.
  always @(posedge clk) begin
    if (!a_rst) rel_edges <= 0;
    else        rel_edges <= rel_edges + 1;
  end

  function automatic bit exp_rdy();
    if (rel_edges == 0) return 1'b0;
    if (STALL_PERIOD < 2) return 1'b1;
    return (rel_edges % STALL_PERIOD) != 0;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every visible output against the reference model.
  always @(negedge clk) begin
    done_t d;
    if (mon_en) begin
      chk("r_ready_out", bus.r_ready_out, exp_rdy());
      chk("pack_done", pack_done, exp_done);
      if (pack_done) begin
        if (exp_q.size() == 0) begin
          chk("done_without_expected_packet", 1, 0);
        end else begin
          d = exp_q.pop_front();
          chk("done_len", pack_len, d.len);
          chk("done_sum", pack_sum, d.sum);
        end
      end
      chk("pack_len", pack_len, exp_len);
      chk("pack_sum", pack_sum, exp_sum);
      chk("pack_cnt", pack_cnt, exp_pack);
      chk("flit_cnt", flit_cnt, exp_flit);
      chk("err_cnt", err_cnt, exp_err);
      chk("busy", busy, exp_busy);
    end
  end

  // One clock cycle: acceptance is decided by what the edge will sample.
  task automatic cycle(output bit acc);
    bit rst_seen;
    @(negedge clk);
    acc      = a_rst && bus.wr_ready_in && bus.r_ready_out;
    rst_seen = a_rst;
    @(posedge clk);
    #1;
    cyc++;
    exp_done = 0;
    if (acc && cyc >= win_lo && cyc <= win_hi) win_acc++;
    if (!rst_seen) begin
      exp_flit = 0; exp_err = 0; exp_pack = 0; exp_len = 0;
      exp_sum = '0; exp_busy = 0;
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    bit acc;
    a_rst = 1'b0;
    bus.wr_ready_in = 1'b1;
    bus.data_i = {1'b1, 4'(ADDR), 8'h00};
    cycle(acc);
    cycle(acc);
    a_rst = 1'b1;
    bus.wr_ready_in = 1'b0;
  endtask

  // Build a packet of n flits; bad_k >= 0 puts a wrong address on that flit.
  task automatic make_pkt(input int n, input int bad_k, input bit bad_ck);
    logic [DATA_SIZE-1:0] x;
    flit_t f;
    pkt.delete();
    x = '0;
    for (int i = 0; i < n; i++) begin
      f.last = (i == n - 1);
      f.addr = (i == bad_k) ? 4'((ADDR + 1 + $urandom_range(0, 14)) % 16) : 4'(ADDR);
      f.data = 8'($urandom);
`ifdef RX_CHECKSUM_EN
      if (i == n - 1) f.data = bad_ck ? (x ^ 8'($urandom_range(1, 255))) : x;
`endif
      x = x ^ f.data;
      pkt.push_back(f);
    end
  endtask

  // Send pkt; its outcome is derived up front from the packet rules.
  task automatic send(input int idle, input int gap_pct, input int abort_after);
    int n, err_at, k, waited;
    logic [DATA_SIZE-1:0] sum_pay, rep;
    bit acc;
    n = pkt.size();
    err_at = -1;
    for (int i = 0; i < n; i++) begin
      if (err_at < 0) begin
        if (pkt[i].addr != 4'(ADDR)) err_at = i;
        else if (i == MAX_PACK_LEN - 1 && i != n - 1) err_at = i;
      end
    end
    sum_pay = '0;
    for (int i = 0; i < n - 1; i++) sum_pay = sum_pay ^ pkt[i].data;
`ifdef RX_CHECKSUM_EN
    if (err_at < 0 && pkt[n-1].data != sum_pay) err_at = n - 1;
    rep = sum_pay;
`else
    rep = sum_pay ^ pkt[n-1].data;
`endif
    bus.wr_ready_in = 1'b0;
    for (int i = 0; i < idle; i++) cycle(acc);
    k = 0;
    waited = 0;
    while (k < n) begin
      bus.data_i = {pkt[k].last, pkt[k].addr, pkt[k].data};
      bus.wr_ready_in = ($urandom_range(0, 99) >= gap_pct);
      cycle(acc);
      if (!acc) begin
        waited++;
        if (waited > 64) begin
          chk("accept_timeout", waited, 0);
          bus.wr_ready_in = 1'b0;
          return;
        end
        continue;
      end
      waited = 0;
      exp_flit = sat(exp_flit);
      if (k == err_at) exp_err = sat(exp_err);
      exp_busy = !pkt[k].last;
      if (k == n - 1 && err_at < 0) begin
        exp_pack = sat(exp_pack);
        exp_len  = n;
        exp_sum  = rep;
        exp_done = 1;
        exp_q.push_back('{n, rep});
      end
      k++;
      if (abort_after > 0 && k == abort_after && k < n) begin
        do_reset();
        return;
      end
    end
  endtask

  initial begin
    bit acc;
    int n, bad_k, ab;
    flit_t f;
    bus.data_i = '0;
    bus.wr_ready_in = 1'b0;
    a_rst = 1'b0;
    cycle(acc);
    mon_en = 1;
    cycle(acc);
    a_rst = 1'b1;

    // 3-flit good packet
    pkt.delete();
    f.addr = 4'(ADDR);
    f.last = 0; f.data = 8'h11; pkt.push_back(f);
    f.last = 0; f.data = 8'h22; pkt.push_back(f);
`ifdef RX_CHECKSUM_EN
    f.last = 1; f.data = 8'h33; pkt.push_back(f);
`else
    f.last = 1; f.data = 8'h44; pkt.push_back(f);
`endif
    send(1, 0, 0);

    // bad address on second flit, then overlength, then 1-flit
    make_pkt(2, -1, 0);
    pkt[1].addr = 4'd5;
    send(2, 0, 0);
    make_pkt(9, -1, 0);
    send(1, 0, 0);
    make_pkt(1, -1, 0);
    send(0, 0, 0);

    // wr_ready_in held high: stall pattern limits a 16-cycle window to 12
    win_lo = cyc + 1;
    win_hi = cyc + 16;
    win_acc = 0;
    while (cyc < win_hi) begin
      make_pkt(1, -1, 0);
      send(0, 0, 0);
    end
    chk("burst_accepts_16_cycles", win_acc, 12);

    // reset mid-packet after 2 flits, then a single-flit packet
    make_pkt(4, -1, 0);
    send(1, 0, 2);
    make_pkt(1, -1, 0);
    send(0, 0, 0);

    // randomized traffic with periodic mid-packet resets
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < 30; p++) begin
        n = $urandom_range(1, 10);
        bad_k = ($urandom_range(0, 99) < 25) ? $urandom_range(0, n - 1) : -1;
        ab = (p == 20 && n >= 2) ? $urandom_range(1, n - 1) : 0;
        make_pkt(n, bad_k, $urandom_range(0, 99) < 15);
        send($urandom_range(0, 2), 20, ab);
      end
    end

    // counter saturation
    do_reset();
    for (int p = 0; p < 40; p++) begin
      make_pkt(1, -1, 0);
      send(0, 0, 0);
    end
    bus.wr_ready_in = 1'b0;
    cycle(acc);
    @(negedge clk);
    chk("flit_cnt_saturated", flit_cnt, CMAX);
    chk("pack_cnt_saturated", pack_cnt, CMAX);

    for (int i = 0; i < 4; i++) cycle(acc);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
